// File: rtl/psram_emu_pkg.sv
// ---------------------------------------------------------------------------
// psram_emu_pkg
// Shared definitions for the PSRAM user-port emulator: command encodings,
// the controller state enum, bus widths and the default parameter values
// used by psram_port_emu and its RAM.
// ---------------------------------------------------------------------------
package psram_emu_pkg;

   // Default parameter values of the emulator
   localparam int DEF_AW           = 10;
   localparam int DEF_CALIB_CYCLES = 64;
   localparam int DEF_READ_LAT     = 8;
   localparam int DEF_BURST        = 4;
   localparam int DEF_TRC          = 2;

   // Fixed user-port widths
   localparam int ADDR_W = 21;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   // Command encodings on the cmd pin
   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_CALIB,
      ST_IDLE,
      ST_WRITE,
      ST_RLAT,
      ST_READ,
      ST_RECOVER
   } psram_state_e;

endpackage

// File: rtl/psram_port_emu_if.sv
// ---------------------------------------------------------------------------
// psram_port_emu_if
// User-port bundle of the PSRAM emulator.
//   init_calib    : emulator ready for commands
//   cmd           : 0 = READ, 1 = WRITE
//   cmd_en        : single-cycle command strobe
//   addr          : burst start address in 32-bit entries
//   wr_data       : write beat data
//   data_mask     : per-byte write mask, bit i = 1 blocks byte i
//   rd_data       : read beat data
//   rd_data_valid : rd_data holds a valid beat
//   cmd_overrun   : sticky flag, a cmd_en was dropped
// master = user logic driving commands, slave = the emulator.
// ---------------------------------------------------------------------------
interface psram_port_emu_if;
   import psram_emu_pkg::*;

   logic              init_calib;
   logic              cmd;
   logic              cmd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [MASK_W-1:0] data_mask;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic              cmd_overrun;

   modport master (
      input  init_calib, rd_data, rd_data_valid, cmd_overrun,
      output cmd, cmd_en, addr, wr_data, data_mask
   );

   modport slave (
      output init_calib, rd_data, rd_data_valid, cmd_overrun,
      input  cmd, cmd_en, addr, wr_data, data_mask
   );

endinterface

// File: rtl/psram_emu_mem.sv
// ---------------------------------------------------------------------------
// psram_emu_mem
// Single-port 2^AW x 32 RAM with byte write enables and a registered read
// port (one cycle latency). Written in the plain inferable style so it maps
// onto block RAM; contents are deliberately not reset.
//   clk   : clock, rising edge
//   we    : write enable
//   be    : byte enables, bit i = 1 writes byte i
//   addr  : entry address (shared by read and write)
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
// ---------------------------------------------------------------------------
module psram_emu_mem
   import psram_emu_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MASK_W-1:0] be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_q;

   // Byte-masked write plus unconditional registered read of the same entry
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (be[i]) begin
               mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/psram_port_emu.sv
// ---------------------------------------------------------------------------
// psram_port_emu
// Behavioural-timing emulator of a PSRAM controller user port. After reset it
// spends CALIB_CYCLES cycles calibrating, then accepts burst commands of BURST
// 32-bit beats. Writes take one beat per cycle starting with the command
// cycle; reads return beats READ_LAT cycles after the command. Each burst is
// followed by TRC recovery cycles. Commands arriving while busy are dropped
// and flagged in a sticky cmd_overrun bit.
//   clk_out : user-port clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : user port (slave side), see psram_port_emu_if
// ---------------------------------------------------------------------------
module psram_port_emu
   import psram_emu_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int CALIB_CYCLES = DEF_CALIB_CYCLES,
   parameter int READ_LAT     = DEF_READ_LAT,
   parameter int BURST        = DEF_BURST,
   parameter int TRC          = DEF_TRC
) (
   input  logic               clk_out,
   input  logic               rst_n,
   psram_port_emu_if.slave    bus
);

   localparam int CNT_W  = 8;
   localparam int BEAT_W = 4;
   localparam int CAL_W  = $clog2(CALIB_CYCLES + 1) + 1;

   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  LAT_ISSUE = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0]  TRC_LAST  = CNT_W'(TRC);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
   localparam logic [BEAT_W-1:0] BURST_N   = BEAT_W'(BURST);
   localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'(CALIB_CYCLES - 1);

   // With no recovery time the burst hands straight back to IDLE
   localparam psram_state_e AFTER_BURST = (TRC == 0) ? ST_IDLE : ST_RECOVER;

   psram_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [AW-1:0]     base_q, base_d;
   logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
   logic              init_calib_q, init_calib_d;
   logic              overrun_q, overrun_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              rd_issue;
   logic              mem_we;
   logic [MASK_W-1:0] mem_be;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Address bits above the emulated depth are ignored by design
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[ADDR_W-1:AW];

   // Next-state logic. cnt_q counts cycles since command acceptance during
   // RLAT and cycles spent in RECOVER; beat_q indexes the burst entry
   // currently addressed in the RAM, so base_q + beat_q is the RAM address
   // in every burst state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      beat_d       = beat_q;
      base_d       = base_q;
      cal_cnt_d    = cal_cnt_q;
      init_calib_d = init_calib_q;
      overrun_d    = overrun_q | (bus.cmd_en & (state_q != ST_IDLE));
      rd_issue     = 1'b0;
      mem_we       = 1'b0;
      mem_be       = '0;
      mem_addr     = base_q + AW'(beat_q);
      mem_wdata    = bus.wr_data;

      case (state_q)
         ST_CALIB: begin
            cal_cnt_d = cal_cnt_q + 1'b1;
            if ((CALIB_CYCLES == 0) || (cal_cnt_q == CAL_LAST)) begin
               state_d      = ST_IDLE;
               init_calib_d = 1'b1;
            end
         end

         ST_IDLE: begin
            if (bus.cmd_en) begin
               base_d = bus.addr[AW-1:0];
               cnt_d  = CNT_ONE;
               beat_d = '0;
               if (bus.cmd == CMD_WRITE) begin
                  // Beat 0 lands in the acceptance cycle itself
                  mem_we   = 1'b1;
                  mem_be   = ~bus.data_mask;
                  mem_addr = bus.addr[AW-1:0];
                  beat_d   = BEAT_ONE;
                  state_d  = (BURST == 1) ? AFTER_BURST : ST_WRITE;
               end else begin
                  state_d = ST_RLAT;
               end
            end
         end

         ST_WRITE: begin
            mem_we = 1'b1;
            mem_be = ~bus.data_mask;
            beat_d = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
               state_d = AFTER_BURST;
               cnt_d   = CNT_ONE;
            end
         end

         ST_RLAT: begin
            cnt_d = cnt_q + 1'b1;
            // RAM read plus output register make two cycles of pipeline,
            // so beat 0 is fetched one cycle before it must appear
            if (cnt_q == LAT_ISSUE) begin
               rd_issue = 1'b1;
               beat_d   = BEAT_ONE;
               state_d  = ST_READ;
            end
         end

         ST_READ: begin
            beat_d = beat_q + 1'b1;
            if (beat_q < BURST_N) begin
               rd_issue = 1'b1;
            end
            // The last beat is registered out on this same edge
            if (beat_q == BURST_N) begin
               state_d = AFTER_BURST;
               cnt_d   = CNT_ONE;
            end
         end

         ST_RECOVER: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TRC_LAST) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_CALIB;
         end
      endcase

      rd_pend_d  = rd_issue;
      rd_valid_d = rd_pend_q;
      rd_data_d  = rd_pend_q ? mem_rdata : rd_data_q;
   end

   // State and output registers; reset aborts any burst in flight
   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_CALIB;
         cnt_q        <= '0;
         beat_q       <= '0;
         base_q       <= '0;
         cal_cnt_q    <= '0;
         init_calib_q <= 1'b0;
         overrun_q    <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         beat_q       <= beat_d;
         base_q       <= base_d;
         cal_cnt_q    <= cal_cnt_d;
         init_calib_q <= init_calib_d;
         overrun_q    <= overrun_d;
         rd_pend_q    <= rd_pend_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   psram_emu_mem #(
      .AW (AW)
   ) u_mem (
      .clk   (clk_out),
      .we    (mem_we),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign bus.init_calib    = init_calib_q;
   assign bus.cmd_overrun   = overrun_q;
   assign bus.rd_data_valid = rd_valid_q;
   assign bus.rd_data       = rd_data_q;

endmodule

// File: tb/tb_psram_port_emu.sv
// ---------------------------------------------------------------------------
// tb_psram_port_emu
// Self-checking bench for psram_port_emu. A memory-array reference model is
// updated on every write burst and read bursts are compared beat by beat at
// the cycle offsets the port timing calls for.
// ---------------------------------------------------------------------------
module tb_psram_port_emu;
   import psram_emu_pkg::*;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int CAL   = 64;
   localparam int LAT   = 8;
   localparam int BL    = 4;
   localparam int TRC   = 2;

   logic clk_out = 1'b0;
   logic rst_n;

   always #5 clk_out = ~clk_out;

   psram_port_emu_if bus ();

   psram_port_emu #(
      .AW           (AW),
      .CALIB_CYCLES (CAL),
      .READ_LAT     (LAT),
      .BURST        (BL),
      .TRC          (TRC)
   ) dut (
      .clk_out (clk_out),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] model [DEPTH];
   logic        overrun_exp;
   logic [31:0] beats [BL];

   // Single comparison point: counts and reports each vector
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Puts random junk on the data pins with no strobe
   task automatic idle_inputs();
      bus.cmd_en    = 1'b0;
      bus.cmd       = 1'($urandom);
      bus.addr      = 21'($urandom);
      bus.wr_data   = $urandom;
      bus.data_mask = 4'($urandom);
   endtask

   // Called at a falling edge; asserts reset, checks reset values, releases
   // on a falling edge three cycles later
   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      #1;
      check_output("rst_init_calib", 32'(bus.init_calib), 32'd0);
      check_output("rst_rd_valid", 32'(bus.rd_data_valid), 32'd0);
      check_output("rst_rd_data", bus.rd_data, 32'd0);
      check_output("rst_overrun", 32'(bus.cmd_overrun), 32'd0);
      overrun_exp = 1'b0;
      repeat (3) @(negedge clk_out);
      rst_n = 1'b1;
   endtask

   // Follows reset release; optionally strobes cmd_en so that it is sampled
   // on rising edge number inject (counted from release)
   task automatic calib_phase(input int inject);
      for (int j = 1; j <= CAL; j++) begin
         @(negedge clk_out);
         check_output("init_calib", 32'(bus.init_calib), 32'(j >= CAL));
         if (inject > 0 && j == inject) overrun_exp = 1'b1;
         if (inject > 0 && (j == inject - 1 || j == inject))
            check_output("calib_overrun", 32'(bus.cmd_overrun), 32'(overrun_exp));
         idle_inputs();
         if (inject > 0 && j == inject - 1) bus.cmd_en = 1'b1;
      end
   endtask

   // Write burst: beat k lives in d[32k+:32] / m[4k+:4]
   task automatic apply_stimulus_write(input logic [20:0] a, input logic [127:0] d,
                                       input logic [15:0] m);
      int base;
      int idx;
      @(negedge clk_out);
      bus.cmd_en    = 1'b1;
      bus.cmd       = CMD_WRITE;
      bus.addr      = a;
      bus.wr_data   = d[31:0];
      bus.data_mask = m[3:0];
      for (int k = 1; k < BL; k++) begin
         @(negedge clk_out);
         idle_inputs();
         bus.wr_data   = d[k*32 +: 32];
         bus.data_mask = m[k*4 +: 4];
      end
      @(negedge clk_out);
      idle_inputs();
      repeat (TRC - 1) @(negedge clk_out);
      base = int'(a) % DEPTH;
      for (int k = 0; k < BL; k++) begin
         idx = (base + k) % DEPTH;
         for (int b = 0; b < 4; b++)
            if (!m[k*4 + b]) model[idx][b*8 +: 8] = d[k*32 + b*8 +: 8];
      end
   endtask

   // Read burst checked cycle by cycle; inject > 0 strobes a stray command
   // so it is sampled inject cycles after acceptance
   task automatic apply_stimulus_read(input logic [20:0] a, input int inject);
      int   base;
      int   k;
      int   idx;
      logic exp_valid;
      base = int'(a) % DEPTH;
      @(negedge clk_out);
      bus.cmd_en = 1'b1;
      bus.cmd    = CMD_READ;
      bus.addr   = a;
      for (int j = 1; j <= LAT + BL + 1; j++) begin
         @(negedge clk_out);
         k = j - 1;
         exp_valid = (k >= LAT) && (k < LAT + BL);
         check_output("rd_valid", 32'(bus.rd_data_valid), 32'(exp_valid));
         if (exp_valid) begin
            idx = (base + k - LAT) % DEPTH;
            beats[k - LAT] = bus.rd_data;
            check_output("rd_beat", bus.rd_data, model[idx]);
         end
         if (k == LAT + BL)
            check_output("rd_hold", bus.rd_data, model[(base + BL - 1) % DEPTH]);
         idle_inputs();
         if (j == inject) begin
            bus.cmd_en = 1'b1;
            bus.cmd    = CMD_WRITE;
         end
      end
   endtask

   initial begin
      logic [20:0]  a;
      logic [127:0] d;
      logic [15:0]  m;

      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk_out);

      // Calibration timing and a command dropped during CALIB
      apply_reset();
      calib_phase(10);

      // Overrun is cleared by the next reset
      @(negedge clk_out);
      apply_reset();
      calib_phase(0);
      check_output("overrun_cleared", 32'(bus.cmd_overrun), 32'd0);

      // Give every entry a known value
      for (int b = 0; b < DEPTH / BL; b++)
         apply_stimulus_write(21'(b * BL), {$urandom, $urandom, $urandom, $urandom}, 16'h0);

      // Random traffic, biased partly towards the top-of-memory wrap
      for (int n = 0; n < 40; n++) begin
         a = 21'($urandom);
         if (n % 4 == 0) a[AW-1:0] = AW'(DEPTH - $urandom_range(1, 3));
         d = {$urandom, $urandom, $urandom, $urandom};
         m = 16'($urandom);
         if ($urandom_range(0, 1) == 1) apply_stimulus_write(a, d, m);
         else apply_stimulus_read(a, 0);
      end

      // Word write with low half masked, read right after recovery
      apply_stimulus_write(21'h000005, {$urandom, $urandom, $urandom, 32'hABCD0000},
                           {12'($urandom), 4'b0011});
      apply_stimulus_read(21'h000005, 0);
      check_output("word_hi", {16'h0, beats[0][31:16]}, 32'h0000ABCD);

      // Byte mask merge
      apply_stimulus_write(21'h000007, {$urandom, $urandom, $urandom, 32'h11223344}, 16'h0);
      apply_stimulus_write(21'h000007, {$urandom, $urandom, $urandom, 32'hAAAAAAAA},
                           {12'hFFF, 4'b1011});
      apply_stimulus_read(21'h000007, 0);
      check_output("byte_mask", beats[0], 32'h11AA3344);

      // Address wrap inside a burst
      apply_stimulus_write(21'h0003FF, {32'd4, 32'd3, 32'd2, 32'd1}, 16'h0);
      apply_stimulus_read(21'h000000, 0);
      check_output("wrap_b0", beats[0], 32'd2);
      check_output("wrap_b1", beats[1], 32'd3);
      check_output("wrap_b2", beats[2], 32'd4);
      apply_stimulus_read(21'h0003FF, 0);
      check_output("wrap_top", beats[0], 32'd1);

      // Stray command during read latency
      check_output("overrun_pre", 32'(bus.cmd_overrun), 32'(overrun_exp));
      apply_stimulus_read(21'($urandom), 3);
      overrun_exp = 1'b1;
      check_output("overrun_rlat", 32'(bus.cmd_overrun), 32'(overrun_exp));
      apply_stimulus_read(21'h000007, 0);

      // Reset in the middle of a read burst
      @(negedge clk_out);
      bus.cmd_en = 1'b1;
      bus.cmd    = CMD_READ;
      bus.addr   = 21'h000000;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk_out);
         idle_inputs();
      end
      check_output("mid_read_valid", 32'(bus.rd_data_valid), 32'd1);
      apply_reset();
      calib_phase(0);
      apply_stimulus_read(21'h000007, 0);
      apply_stimulus_read(21'h0003FF, 0);
      apply_stimulus_read(21'($urandom), 0);
      check_output("overrun_final", 32'(bus.cmd_overrun), 32'(overrun_exp));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/psram_port_emu.md
PSRAM_PORT_EMU -- requirements
Module: psram_port_emu

Interface
REQ-001 SHALL have parameter AW, default 10, meaning log2 of emulated memory depth in 32-bit entries.
REQ-002 SHALL have parameter CALIB_CYCLES, default 64, meaning cycles from reset release to init_calib assertion.
REQ-003 SHALL have parameter READ_LAT, default 8, meaning cycles from read cmd_en to first rd_data_valid; legal range 2..31.
REQ-004 SHALL have parameter BURST, default 4, meaning 32-bit beats per command; legal range 1..8.
REQ-005 SHALL have parameter TRC, default 2, meaning recovery cycles after a burst before the next command is accepted.
REQ-006 SHALL have port clk_out  input  1  user-port clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port init_calib  output  1  emulator ready for commands.
REQ-009 SHALL have port cmd  input  1  command type: 0 = READ, 1 = WRITE.
REQ-010 SHALL have port cmd_en  input  1  single-cycle command strobe.
REQ-011 SHALL have port addr  input  21  burst start address in entry units; only addr[AW-1:0] is used.
REQ-012 SHALL have port wr_data  input  32  write beat data.
REQ-013 SHALL have port data_mask  input  4  per-byte write mask; bit i = 1 blocks byte i.
REQ-014 SHALL have port rd_data  output  32  read beat data.
REQ-015 SHALL have port rd_data_valid  output  1  rd_data holds a valid beat.
REQ-016 SHALL have port cmd_overrun  output  1  sticky flag: a cmd_en was dropped.

Function
REQ-017 SHALL implement states CALIB, IDLE, WRITE, RLAT, READ and RECOVER.
REQ-018 SHALL stay in CALIB for CALIB_CYCLES cycles after reset release, then enter IDLE and drive init_calib = 1 until the next reset.
REQ-019 SHALL accept cmd_en only in IDLE; cmd, addr, wr_data and data_mask are captured at acceptance (cycle T).
REQ-020 For WRITE, SHALL write beat 0 at T and beats k = 1..BURST-1 from wr_data/data_mask at cycle T+k, each to entry (addr+k) mod 2^AW, state WRITE, then enter RECOVER.
REQ-021 SHALL write byte i of an entry only when data_mask[i] = 0; masked bytes keep their old value.
REQ-022 For READ, SHALL assert rd_data_valid at cycles T+READ_LAT .. T+READ_LAT+BURST-1, with beat k = entry (addr+k) mod 2^AW; states RLAT then READ, then RECOVER.
REQ-023 SHALL hold rd_data_valid = 0 outside read beats; rd_data holds the last beat otherwise.
REQ-024 SHALL stay in RECOVER for TRC cycles, then enter IDLE; TRC = 0 means direct return to IDLE.
REQ-025 SHALL address-wrap modulo 2^AW inside a burst (addr = 2^AW-1, BURST 4 -> entries 2^AW-1, 0, 1, 2).
REQ-026 SHALL ignore cmd_en in any state other than IDLE (including CALIB) and set cmd_overrun = 1, which stays set until reset.
REQ-027 SHALL ignore wr_data/data_mask in cycles that are not write beats.
REQ-028 A read issued in the cycle right after a write burst's RECOVER completes SHALL return the newly written data.

Reset
REQ-029 Asserting rst_n low SHALL immediately force the state to CALIB, init_calib = 0, rd_data_valid = 0, rd_data = 0, cmd_overrun = 0, and clear the calibration counter.
REQ-030 Reset mid-burst SHALL abort the burst without emitting further beats; memory contents are not cleared, and beats already written remain.

Structure
REQ-031 Package psram_emu_pkg SHALL hold CMD_READ/CMD_WRITE constants, the state enum, and the default parameter values.
REQ-032 Storage SHALL be the sub-module psram_emu_mem: a single-port 2^AW x 32 RAM with byte write enables and registered read (latency 1), which maps to BSRAM.

Verification
REQ-033 Calibration: release reset -> init_calib rises exactly 64 cycles later; cmd_en at cycle 10 -> ignored, cmd_overrun = 1.
REQ-034 Word write/read: WRITE addr 0x000005, wr_data 0xABCD0000, mask 0011, then READ addr 5 -> first beat rd_data[31:16] = 0xABCD at T+8, with 4 valid beats.
REQ-035 Byte mask: entry 7 = 0x11223344; WRITE 0xAAAAAAAA, mask 1011 -> read returns 0x11AA3344.
REQ-036 Wrap: WRITE burst at addr 0x3FF, data 1, 2, 3, 4 -> READ at addr 0 returns 2, 3, 4, prior entry 3.
REQ-037 Overrun: cmd_en during RLAT -> burst unaffected, cmd_overrun = 1; second command after RECOVER accepted.
REQ-038 Reset mid-read at T+9 -> rd_data_valid = 0 at once, init_calib = 0, calibration restarts, and data written earlier is still readable afterwards.
